// File: rtl/seq_det_pkg.sv
// Shared definitions for the 1010 generator and detector blocks: state
// encodings, the pattern itself and the Moore output decode.
package seq_det_pkg;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'b000,
        ST_S1    = 3'b001,
        ST_S10   = 3'b010,
        ST_S101  = 3'b011,
        ST_S1010 = 3'b100,
        ST_GAP   = 3'b101,
        ST_DONE  = 3'b110
    } state_t;

    localparam logic [3:0] PATTERN = 4'b1010;

    // Serial bit carried by each state; pattern states walk PATTERN MSB first.
    function automatic logic state_op(input state_t st);
        logic bit_out;
        bit_out = 1'b0;
        case (st)
            ST_S1:    bit_out = PATTERN[3];
            ST_S10:   bit_out = PATTERN[2];
            ST_S101:  bit_out = PATTERN[1];
            ST_S1010: bit_out = PATTERN[0];
            default:  bit_out = 1'b0;
        endcase
        return bit_out;
    endfunction

endpackage

// File: rtl/seq_gen_dcnt.sv
// Loadable down-counter with clear, load and decrement; saturates at zero.
module seq_gen_dcnt #(
    parameter int W = 4
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         clear,
    input  logic         load,
    input  logic         dec,
    input  logic [W-1:0] load_val,
    output logic [W-1:0] value,
    output logic         zero
);

    always_ff @(posedge clk) begin
        if (rst || clear) begin
            value <= '0;
        end else if (load) begin
            value <= load_val;
        end else if (dec && (value != '0)) begin
            value <= value - W'(1);
        end
    end

    assign zero = (value == '0);

endmodule

// File: rtl/moore_1010_seq_gen.sv
// Serial 1010 frame transmitter: Count copies of the pattern separated by Gap
// zero bits, followed by a one-cycle Done. Outputs are registered Moore decodes.
module moore_1010_seq_gen
    import seq_det_pkg::*;
#(
    parameter int CNT_W = 4,
    parameter int GAP_W = 3
) (
    input  logic             Clk,
    input  logic             Rst,
    input  logic             Start,
    input  logic [CNT_W-1:0] Count,
    input  logic [GAP_W-1:0] Gap,
    input  logic             Abort,
    output logic             OP,
    output logic             Valid,
    output logic             Busy,
    output logic             Done,
    output logic [2:0]       CS,
    output logic [2:0]       NS
);

    state_t           state_q;
    state_t           state_d;
    logic [GAP_W-1:0] gap_lat;
    logic [CNT_W-1:0] frm_cnt;
    logic             frm_zero;
    logic [GAP_W-1:0] gap_cnt;
    logic             gap_zero;
    logic             start_ok;
    logic             abort_ok;
    logic             last_pat;

    assign start_ok = (state_q == ST_IDLE) && Start && (Count != '0);
    assign abort_ok = (state_q != ST_IDLE) && Abort;
    assign last_pat = frm_zero || (frm_cnt == CNT_W'(1));

    always_comb begin
        state_d = ST_IDLE;
        case (state_q)
            ST_IDLE:  state_d = start_ok ? ST_S1 : ST_IDLE;
            ST_S1:    state_d = ST_S10;
            ST_S10:   state_d = ST_S101;
            ST_S101:  state_d = ST_S1010;
            ST_S1010: begin
                if (last_pat)
                    state_d = ST_DONE;
                else if (gap_lat == '0)
                    state_d = ST_S1;
                else
                    state_d = ST_GAP;
            end
            // Counter was loaded with Gap, so leaving at 1 yields exactly Gap zeros.
            ST_GAP:   state_d = (gap_zero || (gap_cnt == GAP_W'(1))) ? ST_S1 : ST_GAP;
            ST_DONE:  state_d = ST_IDLE;
            default:  state_d = ST_IDLE;
        endcase
        if (abort_ok || Rst)
            state_d = ST_IDLE;
    end

    seq_gen_dcnt #(.W(CNT_W)) u_frm_cnt (
        .clk      (Clk),
        .rst      (Rst),
        .clear    (abort_ok),
        .load     (start_ok),
        .dec      (state_q == ST_S1010),
        .load_val (Count),
        .value    (frm_cnt),
        .zero     (frm_zero)
    );

    seq_gen_dcnt #(.W(GAP_W)) u_gap_cnt (
        .clk      (Clk),
        .rst      (Rst),
        .clear    (abort_ok),
        .load     ((state_q == ST_S1010) && !last_pat && (gap_lat != '0)),
        .dec      (state_q == ST_GAP),
        .load_val (gap_lat),
        .value    (gap_cnt),
        .zero     (gap_zero)
    );

    // Outputs are registered from the next state so they track the state register exactly.
    always_ff @(posedge Clk) begin
        if (Rst) begin
            state_q <= ST_IDLE;
            gap_lat <= '0;
            OP      <= 1'b0;
            Valid   <= 1'b0;
            Busy    <= 1'b0;
            Done    <= 1'b0;
        end else begin
            state_q <= state_d;
            if (start_ok)
                gap_lat <= Gap;
            else if (abort_ok)
                gap_lat <= '0;
            OP      <= state_op(state_d);
            Valid   <= (state_d != ST_IDLE) && (state_d != ST_DONE);
            Busy    <= (state_d != ST_IDLE);
            Done    <= (state_d == ST_DONE);
        end
    end

    assign CS = state_q;
    assign NS = state_d;

endmodule

// File: tb/tb_moore_1010_seq_gen.sv
// Self-checking bench: a queue of expected per-cycle outputs built from the
// frame rules, compared against the DUT every cycle, plus directed literal checks.
module tb_moore_1010_seq_gen;

    logic       Clk = 1'b0;
    logic       Rst = 1'b1;
    logic       Start = 1'b0;
    logic [3:0] Count = '0;
    logic [2:0] Gap = '0;
    logic       Abort = 1'b0;
    logic       OP, Valid, Busy, Done;
    logic [2:0] CS, NS;

    moore_1010_seq_gen #(.CNT_W(4), .GAP_W(3)) dut (
        .Clk(Clk), .Rst(Rst), .Start(Start), .Count(Count), .Gap(Gap),
        .Abort(Abort), .OP(OP), .Valid(Valid), .Busy(Busy), .Done(Done),
        .CS(CS), .NS(NS)
    );

    always #5 Clk = ~Clk;

    typedef struct packed {
        logic       op;
        logic       valid;
        logic       busy;
        logic       done;
        logic [2:0] cs;
    } exp_t;

    exp_t        q[$];
    exp_t        exp_now;
    int          checks = 0;
    int          failures = 0;
    logic [63:0] cap = '0;
    int          cap_n = 0;
    int          done_n = 0;
    int          gap_n = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h at %0t", name, act, req, $time);
        end
    endtask

    // Whole frame as the list of output vectors it must produce, one per cycle.
    function automatic void build_frame(input int c, input int g);
        for (int i = 0; i < c; i++) begin
            q.push_back('{1'b1, 1'b1, 1'b1, 1'b0, 3'd1});
            q.push_back('{1'b0, 1'b1, 1'b1, 1'b0, 3'd2});
            q.push_back('{1'b1, 1'b1, 1'b1, 1'b0, 3'd3});
            q.push_back('{1'b0, 1'b1, 1'b1, 1'b0, 3'd4});
            if (i < c - 1)
                for (int j = 0; j < g; j++)
                    q.push_back('{1'b0, 1'b1, 1'b1, 1'b0, 3'd5});
        end
        q.push_back('{1'b0, 1'b0, 1'b1, 1'b1, 3'd6});
    endfunction

    always @(posedge Clk) begin
        if (Rst)
            q.delete();
        else if (q.size() != 0) begin
            if (Abort)
                q.delete();
            else
                void'(q.pop_front());
        end else if (Start && (Count != 0))
            build_frame(int'(Count), int'(Gap));
        exp_now = (q.size() != 0) ? q[0] : exp_t'('0);
        #1;
        check("op",    64'(OP),    64'(exp_now.op));
        check("valid", 64'(Valid), 64'(exp_now.valid));
        check("busy",  64'(Busy),  64'(exp_now.busy));
        check("done",  64'(Done),  64'(exp_now.done));
        check("cs",    64'(CS),    64'(exp_now.cs));
        if (Valid === 1'b1) begin
            cap   = {cap[62:0], OP};
            cap_n = cap_n + 1;
        end
        if (Done === 1'b1) done_n = done_n + 1;
        if (CS == 3'd5)    gap_n  = gap_n + 1;
    end

    task automatic clr_cap();
        cap = '0; cap_n = 0; done_n = 0; gap_n = 0;
    endtask

    task automatic start_frame(input logic [3:0] c, input logic [2:0] g);
        clr_cap();
        Count = c; Gap = g; Start = 1'b1;
        @(negedge Clk);
        Start = 1'b0;
    endtask

    initial begin
        int      hits;
        logic    found;
        logic [11:0] s12;

        // 1: reset held with Start high
        Start = 1'b1; Count = 4'd1;
        repeat (2) @(negedge Clk);
        check("rst_cs",   64'(CS),   64'd0);
        check("rst_busy", 64'(Busy), 64'd0);
        check("rst_ns",   64'(NS),   64'd0);
        check("rst_op",   64'(OP),   64'd0);
        Start = 1'b0; Rst = 1'b0;
        @(negedge Clk);

        // 2: single pattern
        start_frame(4'd1, 3'd0);
        repeat (6) @(negedge Clk);
        check("t2_bits", 64'(cap[3:0]), 64'h a);
        check("t2_len",  64'(cap_n),    64'd4);
        check("t2_done", 64'(done_n),   64'd1);
        check("t2_idle", 64'(CS),       64'd0);

        // 3: three back-to-back patterns
        start_frame(4'd3, 3'd0);
        repeat (14) @(negedge Clk);
        check("t3_bits", 64'(cap[11:0]), 64'h aaa);
        check("t3_len",  64'(cap_n),     64'd12);
        check("t3_done", 64'(done_n),    64'd1);
        s12 = cap[11:0];
        hits = 0;
        for (int i = 11; i >= 3; ) begin
            if (s12[i -: 4] == 4'b1010) begin hits++; i -= 4; end
            else i--;
        end
        check("t3_det", 64'(hits), 64'd3);

        // 4: gap of two, with a mid-frame Start/Count change that must be ignored
        start_frame(4'd2, 3'd2);
        repeat (3) @(negedge Clk);
        Start = 1'b1; Count = 4'd5;
        @(negedge Clk);
        Start = 1'b0;
        repeat (9) @(negedge Clk);
        check("t4_bits", 64'(cap[9:0]), 64'(10'b1010001010));
        check("t4_len",  64'(cap_n),    64'd10);
        check("t4_gap",  64'(gap_n),    64'd2);
        check("t4_done", 64'(done_n),   64'd1);

        // 5: abort in S101 of the second pattern
        start_frame(4'd4, 3'd0);
        found = 1'b0;
        for (int i = 0; i < 20 && !found; i++) begin
            if (CS == 3'd3 && cap_n > 4) found = 1'b1;
            else @(negedge Clk);
        end
        check("t5_reach", 64'(found), 64'd1);
        Abort = 1'b1;
        @(negedge Clk);
        Abort = 1'b0;
        check("t5_cs",   64'(CS),     64'd0);
        check("t5_op",   64'(OP),     64'd0);
        check("t5_busy", 64'(Busy),   64'd0);
        repeat (2) @(negedge Clk);
        check("t5_done", 64'(done_n), 64'd0);
        start_frame(4'd1, 3'd3);
        repeat (6) @(negedge Clk);
        check("t5_bits", 64'(cap[3:0]), 64'h a);
        check("t5_len",  64'(cap_n),    64'd4);

        // 6: zero count, then reset during a gap
        start_frame(4'd0, 3'd1);
        repeat (3) @(negedge Clk);
        check("t6_busy", 64'(Busy),   64'd0);
        check("t6_done", 64'(done_n), 64'd0);
        start_frame(4'd2, 3'd5);
        found = 1'b0;
        for (int i = 0; i < 20 && !found; i++) begin
            if (CS == 3'd5) found = 1'b1;
            else @(negedge Clk);
        end
        check("t6_reach", 64'(found), 64'd1);
        Rst = 1'b1;
        @(negedge Clk);
        Rst = 1'b0;
        check("t6_cs",   64'(CS),   64'd0);
        check("t6_busy", 64'(Busy), 64'd0);

        // Random traffic against the queue model
        for (int i = 0; i < 3000; i++) begin
            @(negedge Clk);
            Start = ($urandom % 4) == 0;
            Count = 4'($urandom_range(0, 4));
            Gap   = 3'($urandom_range(0, 3));
            Abort = ($urandom % 40) == 0;
            Rst   = ($urandom % 200) == 0;
        end
        @(negedge Clk);
        Start = 1'b0; Abort = 1'b0; Rst = 1'b0;
        repeat (3) @(negedge Clk);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
